// File: rtl/regfile.sv
// swt16 general-purpose register file: one writeback port, two registered read ports with bypass, busy scoreboard.
// Read latency is 1 cycle and a same-edge write is bypassed; there is no back-pressure, so every write is accepted.
module regfile #(
    parameter int IALU_WORD_WIDTH = 16,
    parameter int REG_IDX_WIDTH   = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_act_write_res_to_reg,
    input  logic [IALU_WORD_WIDTH-1:0] in_res,
    input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
    input  logic [REG_IDX_WIDTH-1:0]   in_rd_idx_a,
    input  logic [REG_IDX_WIDTH-1:0]   in_rd_idx_b,
    input  logic                       in_stall,
    input  logic                       in_act_mark_busy,
    input  logic [REG_IDX_WIDTH-1:0]   in_mark_reg_idx,
    output logic [IALU_WORD_WIDTH-1:0] out_val_a,
    output logic [IALU_WORD_WIDTH-1:0] out_val_b,
    output logic                       out_busy_a,
    output logic                       out_busy_b
);

    localparam int NREGS = 1 << REG_IDX_WIDTH;

    logic [IALU_WORD_WIDTH-1:0] regs [NREGS];
    logic [NREGS-1:0]           busy;
    logic [NREGS-1:0]           busy_next;
    logic [REG_IDX_WIDTH-1:0]   idx_a_q;
    logic [REG_IDX_WIDTH-1:0]   idx_b_q;
    logic [REG_IDX_WIDTH-1:0]   sel_a;
    logic [REG_IDX_WIDTH-1:0]   sel_b;
    logic                       hit_a;
    logic                       hit_b;
    logic [IALU_WORD_WIDTH-1:0] rd_a;
    logic [IALU_WORD_WIDTH-1:0] rd_b;

    always_comb begin
        sel_a = in_stall ? idx_a_q : in_rd_idx_a;
        sel_b = in_stall ? idx_b_q : in_rd_idx_b;
    end

    // Mark is applied after clear so a re-issued producer keeps the register busy.
    always_comb begin
        busy_next = busy;
        if (in_act_write_res_to_reg) begin
            busy_next[in_res_reg_idx] = 1'b0;
        end
        if (in_act_mark_busy) begin
            busy_next[in_mark_reg_idx] = 1'b1;
        end
    end

    always_comb begin
        hit_a = in_act_write_res_to_reg && (in_res_reg_idx == sel_a);
        hit_b = in_act_write_res_to_reg && (in_res_reg_idx == sel_b);
        rd_a  = hit_a ? in_res : regs[sel_a];
        rd_b  = hit_b ? in_res : regs[sel_b];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (in_act_write_res_to_reg) begin
            regs[in_res_reg_idx] <= in_res;
        end
    end

    // Outputs refresh even while stalled so a held operand tracks mid-stall writeback.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy       <= '0;
            idx_a_q    <= '0;
            idx_b_q    <= '0;
            out_val_a  <= '0;
            out_val_b  <= '0;
            out_busy_a <= 1'b0;
            out_busy_b <= 1'b0;
        end else begin
            busy       <= busy_next;
            out_val_a  <= rd_a;
            out_val_b  <= rd_b;
            out_busy_a <= busy_next[sel_a];
            out_busy_b <= busy_next[sel_b];
            if (!in_stall) begin
                idx_a_q <= in_rd_idx_a;
                idx_b_q <= in_rd_idx_b;
            end
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: reset, write/read, bypass, stall freshness and scoreboard set/clear.
module tb_regfile;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_act_write_res_to_reg = 1'b0;
    logic [15:0] in_res = '0;
    logic [3:0]  in_res_reg_idx = '0;
    logic [3:0]  in_rd_idx_a = '0;
    logic [3:0]  in_rd_idx_b = '0;
    logic        in_stall = 1'b0;
    logic        in_act_mark_busy = 1'b0;
    logic [3:0]  in_mark_reg_idx = '0;
    logic [15:0] out_val_a;
    logic [15:0] out_val_b;
    logic        out_busy_a;
    logic        out_busy_b;

    int checks = 0;
    int errors = 0;

    regfile #(.IALU_WORD_WIDTH(16), .REG_IDX_WIDTH(4)) dut (
        .clock                   (clock),
        .reset                   (reset),
        .in_act_write_res_to_reg (in_act_write_res_to_reg),
        .in_res                  (in_res),
        .in_res_reg_idx          (in_res_reg_idx),
        .in_rd_idx_a             (in_rd_idx_a),
        .in_rd_idx_b             (in_rd_idx_b),
        .in_stall                (in_stall),
        .in_act_mark_busy        (in_act_mark_busy),
        .in_mark_reg_idx         (in_mark_reg_idx),
        .out_val_a               (out_val_a),
        .out_val_b               (out_val_b),
        .out_busy_a              (out_busy_a),
        .out_busy_b              (out_busy_b)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic en, input logic [3:0] idx, input logic [15:0] dat);
        in_act_write_res_to_reg = en;
        in_res_reg_idx          = idx;
        in_res                  = dat;
    endtask

    task automatic mark(input logic en, input logic [3:0] idx);
        in_act_mark_busy = en;
        in_mark_reg_idx  = idx;
    endtask

    initial begin
        #12;
        reset = 1'b0;
        check("rst_val_a", out_val_a, 16'h0000);
        check("rst_val_b", out_val_b, 16'h0000);
        check("rst_busy_a", {15'b0, out_busy_a}, 16'h0000);
        check("rst_busy_b", {15'b0, out_busy_b}, 16'h0000);

        // Write r5 and mark it busy in the same cycle, reading it through A.
        wr(1'b1, 4'd5, 16'hBEEF);
        mark(1'b1, 4'd5);
        in_rd_idx_a = 4'd5;
        tick();
        check("pre_rst_val_a", out_val_a, 16'hBEEF);
        check("pre_rst_busy_a", {15'b0, out_busy_a}, 16'h0001);
        wr(1'b0, 4'd0, 16'h0000);
        mark(1'b0, 4'd0);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_val_a", out_val_a, 16'h0000);
        check("async_rst_busy_a", {15'b0, out_busy_a}, 16'h0000);
        #1;
        reset = 1'b0;
        tick();
        check("post_rst_r5_val", out_val_a, 16'h0000);
        check("post_rst_r5_busy", {15'b0, out_busy_a}, 16'h0000);

        // Write then read.
        wr(1'b1, 4'd3, 16'h1234);
        tick();
        wr(1'b0, 4'd0, 16'h0000);
        in_rd_idx_a = 4'd3;
        in_rd_idx_b = 4'd0;
        tick();
        check("wr_rd_a_r3", out_val_a, 16'h1234);
        check("wr_rd_b_r0", out_val_b, 16'h0000);

        // Bypass on both ports.
        wr(1'b1, 4'd7, 16'h0001);
        tick();
        wr(1'b1, 4'd7, 16'hA5A5);
        in_rd_idx_a = 4'd7;
        in_rd_idx_b = 4'd7;
        tick();
        check("bypass_a", out_val_a, 16'hA5A5);
        check("bypass_b", out_val_b, 16'hA5A5);
        wr(1'b0, 4'd0, 16'h0000);
        tick();
        check("bypass_persist_a", out_val_a, 16'hA5A5);

        // Stall freshness.
        wr(1'b1, 4'd2, 16'h0010);
        tick();
        wr(1'b1, 4'd9, 16'h0999);
        in_rd_idx_a = 4'd2;
        tick();
        check("stall_pre_a", out_val_a, 16'h0010);
        wr(1'b0, 4'd0, 16'h0000);
        in_stall    = 1'b1;
        in_rd_idx_a = 4'd9;
        tick();
        check("stall_hold_a", out_val_a, 16'h0010);
        wr(1'b1, 4'd2, 16'h0020);
        tick();
        check("stall_fresh_a", out_val_a, 16'h0020);
        wr(1'b0, 4'd0, 16'h0000);
        tick();
        check("stall_fresh_hold_a", out_val_a, 16'h0020);
        in_stall = 1'b0;
        tick();
        check("unstall_r9_a", out_val_a, 16'h0999);

        // Scoreboard: set, set-wins-over-clear, clear.
        mark(1'b1, 4'd4);
        in_rd_idx_a = 4'd4;
        tick();
        check("sb_mark_busy_a", {15'b0, out_busy_a}, 16'h0001);
        wr(1'b1, 4'd4, 16'h00FF);
        tick();
        check("sb_setwins_busy_a", {15'b0, out_busy_a}, 16'h0001);
        check("sb_setwins_val_a", out_val_a, 16'h00FF);
        mark(1'b0, 4'd0);
        wr(1'b1, 4'd4, 16'h0100);
        tick();
        check("sb_clear_busy_a", {15'b0, out_busy_a}, 16'h0000);
        check("sb_clear_val_a", out_val_a, 16'h0100);

        // Independent set and clear on different indices.
        wr(1'b0, 4'd0, 16'h0000);
        mark(1'b1, 4'd6);
        in_rd_idx_b = 4'd6;
        tick();
        check("sb_r6_busy_b", {15'b0, out_busy_b}, 16'h0001);
        mark(1'b1, 4'd1);
        wr(1'b1, 4'd6, 16'h0066);
        in_rd_idx_a = 4'd1;
        tick();
        check("sb_indep_busy_a_r1", {15'b0, out_busy_a}, 16'h0001);
        check("sb_indep_busy_b_r6", {15'b0, out_busy_b}, 16'h0000);
        check("sb_indep_val_b_r6", out_val_b, 16'h0066);
        mark(1'b0, 4'd0);
        wr(1'b0, 4'd0, 16'h0000);
        tick();
        check("sb_hold_busy_a_r1", {15'b0, out_busy_a}, 16'h0001);
        check("sb_hold_busy_b_r6", {15'b0, out_busy_b}, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
